// File: rtl/demux_1to3_buf_pkg.sv
// demux_1to3_buf_pkg
//   Shared definitions for the buffered 1-to-3 demultiplexer:
//   - destination select codes (DEMUX_SEL_D0/D1/D2/ILL)
//   - the holding-slot state encoding
//   - a small helper that maps a destination index to its select code
package demux_1to3_buf_pkg;

  localparam logic [1:0] DEMUX_SEL_D0  = 2'b00;
  localparam logic [1:0] DEMUX_SEL_D1  = 2'b01;
  localparam logic [1:0] DEMUX_SEL_D2  = 2'b10;
  localparam logic [1:0] DEMUX_SEL_ILL = 2'b11;

  localparam int unsigned N_DEST = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select code that addresses destination index k.
  function automatic logic [1:0] dest_code(input int unsigned k);
    logic [1:0] code;
    case (k)
      0:       code = DEMUX_SEL_D0;
      1:       code = DEMUX_SEL_D1;
      2:       code = DEMUX_SEL_D2;
      default: code = DEMUX_SEL_ILL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/demux_1to3_buf_slot.sv
// demux_slot
//   One-entry valid/ready holding register (EMPTY/FULL).
//   Ports:
//     clock, reset_n   rising-edge clock, async active-low reset
//     push             write wdata into the slot this cycle
//     wdata            word to store
//     pop_ready        consumer accepts the held word (pop when valid)
//     valid            slot FULL
//     rdata            held word (stable while FULL until popped)
//     can_push         slot can take a word this cycle (empty, or draining now)
module demux_slot
  import demux_1to3_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             can_push
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             pop_s;
  logic             accept_s;

  assign pop_s    = (state_q == SLOT_FULL) & pop_ready;
  assign can_push = (state_q == SLOT_EMPTY) | pop_ready;
  // A push into a FULL slot that is not draining would destroy the held word.
  assign accept_s = push & can_push;

  assign valid = (state_q == SLOT_FULL);
  assign rdata = data_q;

  // Next-state and next-data for the slot.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept_s) begin
          state_d = SLOT_FULL;
        end else begin
          state_d = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        // Pop together with push keeps the slot FULL with the new word.
        if (pop_s && !accept_s) begin
          state_d = SLOT_EMPTY;
        end else begin
          state_d = SLOT_FULL;
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
    if (accept_s) begin
      data_d = wdata;
    end else begin
      data_d = data_q;
    end
  end

  // Slot state and data registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_1to3_buf.sv
// demux_1to3_buf
//   Buffered 1-to-3 demultiplexer. One valid/ready input stream tagged with a
//   2-bit select is steered into one of three one-entry slots; each slot drains
//   through its own valid/ready handshake. Select 2'b11 is illegal: the word is
//   accepted and dropped, and sel_err is set until reset.
//   Optional feature macro: DEMUX_STATS_EN builds per-destination delivery
//   counters and a drop counter; without it the counter ports read 0.
//   Ports:
//     clock, reset_n           rising-edge clock, async active-low reset
//     in_valid/in_ready        input handshake
//     in_sel, in_data          destination select and word
//     out_valid[2:0]           per-destination slot full
//     out_ready[2:0]           per-destination consumer accepts
//     out_data0/1/2            slot contents
//     sel_err                  sticky illegal-select flag
//     cnt0/1/2, cnt_drop       delivered / dropped word counters
module demux_1to3_buf
  import demux_1to3_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [2:0]       out_valid,
  input  logic [2:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic             sel_err,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt_drop
);

  logic [2:0]       can_push_s;
  logic [2:0]       push_s;
  logic [2:0]       pop_s;
  logic             ill_accept_s;
  logic [WIDTH-1:0] slot_data_s [0:2];
  logic             sel_err_q, sel_err_d;

  // in_ready looks only at the addressed slot; illegal words are always taken.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      DEMUX_SEL_D0:  in_ready = can_push_s[0];
      DEMUX_SEL_D1:  in_ready = can_push_s[1];
      DEMUX_SEL_D2:  in_ready = can_push_s[2];
      DEMUX_SEL_ILL: in_ready = 1'b1;
      default:       in_ready = 1'b1;
    endcase
  end

  assign ill_accept_s = in_valid & in_ready & (in_sel == DEMUX_SEL_ILL);
  assign pop_s        = out_valid & out_ready;

  for (genvar k = 0; k < N_DEST; k++) begin : g_slot
    assign push_s[k] = in_valid & in_ready & (in_sel == dest_code(k));

    demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push_s[k]),
      .wdata     (in_data),
      .pop_ready (out_ready[k]),
      .valid     (out_valid[k]),
      .rdata     (slot_data_s[k]),
      .can_push  (can_push_s[k])
    );
  end

  assign out_data0 = slot_data_s[0];
  assign out_data1 = slot_data_s[1];
  assign out_data2 = slot_data_s[2];

  // Sticky illegal-select flag, next value.
  always_comb begin
    sel_err_d = sel_err_q;
    if (ill_accept_s) begin
      sel_err_d = 1'b1;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // Sticky illegal-select flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;
  logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

  // Counter increments; all wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    cnt_drop_d = cnt_drop_q;
    if (pop_s[0]) begin
      cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt0_d = cnt0_q;
    end
    if (pop_s[1]) begin
      cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt1_d = cnt1_q;
    end
    if (pop_s[2]) begin
      cnt2_d = cnt2_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt2_d = cnt2_q;
    end
    if (ill_accept_s) begin
      cnt_drop_d = cnt_drop_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_drop_d = cnt_drop_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q     <= {CNT_W{1'b0}};
      cnt1_q     <= {CNT_W{1'b0}};
      cnt2_q     <= {CNT_W{1'b0}};
      cnt_drop_q <= {CNT_W{1'b0}};
    end else begin
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;
  assign cnt2     = cnt2_q;
  assign cnt_drop = cnt_drop_q;
`else
  assign cnt0     = {CNT_W{1'b0}};
  assign cnt1     = {CNT_W{1'b0}};
  assign cnt2     = {CNT_W{1'b0}};
  assign cnt_drop = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_demux_1to3_buf.sv
// tb_demux_1to3_buf
//   Directed self-checking bench for demux_1to3_buf with hand-computed
//   expected values. Counter expectations depend on whether DEMUX_STATS_EN
//   is defined for the build.
module tb_demux_1to3_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       out_valid;
  logic [2:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic             sel_err;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt_drop;

  int n_checks;
  int n_errors;

  demux_1to3_buf #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .sel_err   (sel_err),
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt_drop  (cnt_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] st(input int n);
    return STATS ? 64'(n) : 64'd0;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = 32'h0;
    out_ready = 3'b000;

    // 1 Reset state
    #12;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sel_err",   64'(sel_err),   64'd0);
    check_eq("rst_data0",     64'(out_data0), 64'd0);
    check_eq("rst_cnt2",      64'(cnt2),      64'd0);
    check_eq("rst_cnt_drop",  64'(cnt_drop),  64'd0);
    #2 reset_n = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check_eq($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
    end

    // 2 Steer one word to each slot, consumers stalled
    in_valid = 1'b1;
    in_sel = 2'b00; in_data = 32'hAAAA0000; tick();
    in_sel = 2'b01; in_data = 32'hBBBB0001; tick();
    in_sel = 2'b10; in_data = 32'hCCCC0002; tick();
    in_valid = 1'b0;
    check_eq("steer_out_valid", 64'(out_valid), 64'h7);
    check_eq("steer_data0", 64'(out_data0), 64'hAAAA0000);
    check_eq("steer_data1", 64'(out_data1), 64'hBBBB0001);
    check_eq("steer_data2", 64'(out_data2), 64'hCCCC0002);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      check_eq($sformatf("steer_in_ready_sel%0d", s), 64'(in_ready), (s == 3) ? 64'd1 : 64'd0);
    end

    // 3 Backpressure on slot 1, then pop+push on the same edge
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h11110001; out_ready = 3'b000;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
      tick();
    end
    check_eq("bp_data1_held", 64'(out_data1), 64'hBBBB0001);
    out_ready = 3'b010;
    #1;
    check_eq("bp_in_ready_open", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    check_eq("bp_out_valid", 64'(out_valid), 64'h7);
    check_eq("bp_data1_new", 64'(out_data1), 64'h11110001);
    check_eq("bp_cnt1",      64'(cnt1),      st(1));

    // 4 Streaming into slot 2 while it drains every cycle
    out_ready = 3'b100;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 2'b10; in_data = 32'(i);
      #1;
      check_eq($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'd1);
      check_eq($sformatf("stream_pop_%0d", i), 64'(out_data2), (i == 0) ? 64'hCCCC0002 : 64'(i - 1));
      tick();
      check_eq($sformatf("stream_valid_%0d", i), 64'(out_valid[2]), 64'd1);
    end
    in_valid = 1'b0;
    check_eq("stream_last", 64'(out_data2), 64'd7);
    tick();
    out_ready = 3'b000;
    check_eq("stream_drained", 64'(out_valid), 64'h3);
    check_eq("stream_cnt2",    64'(cnt2),      st(9));

    // 5 Illegal select
    in_valid = 1'b1; in_sel = 2'b11; in_data = 32'h0000DEAD;
    #1;
    check_eq("ill_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; in_sel = 2'b00;
    check_eq("ill_out_valid", 64'(out_valid), 64'h3);
    check_eq("ill_sel_err",   64'(sel_err),   64'd1);
    check_eq("ill_cnt_drop",  64'(cnt_drop),  st(1));
    check_eq("ill_data0",     64'(out_data0), 64'hAAAA0000);
    tick(); tick();
    check_eq("ill_sticky",    64'(sel_err),   64'd1);
    check_eq("idle_out_valid", 64'(out_valid), 64'h3);

    // Simultaneous pops on slots 0,1 plus a push to slot 2
    out_ready = 3'b111;
    in_valid = 1'b1; in_sel = 2'b10; in_data = 32'h22220002;
    tick();
    in_valid = 1'b0; out_ready = 3'b000;
    check_eq("multi_out_valid", 64'(out_valid), 64'h4);
    check_eq("multi_data2",     64'(out_data2), 64'h22220002);
    check_eq("multi_cnt0",      64'(cnt0),      st(1));
    check_eq("multi_cnt1",      64'(cnt1),      st(2));

    // 6 Reset in the middle of operation
    in_valid = 1'b1; in_sel = 2'b00; in_data = 32'h33330000;
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_valid", 64'(out_valid), 64'h5);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid",   64'(out_valid), 64'd0);
    check_eq("mid_rst_sel_err", 64'(sel_err),   64'd0);
    check_eq("mid_rst_cnt2",    64'(cnt2),      64'd0);
    check_eq("mid_rst_data0",   64'(out_data0), 64'd0);
    check_eq("mid_rst_ready",   64'(in_ready),  64'd1);
    #2 reset_n = 1'b1;
    tick();
    in_valid = 1'b1; in_sel = 2'b01; in_data = 32'h44440001;
    tick();
    in_valid = 1'b0;
    check_eq("post_rst_valid", 64'(out_valid), 64'h2);
    check_eq("post_rst_data1", 64'(out_data1), 64'h44440001);
    out_ready = 3'b010;
    tick();
    out_ready = 3'b000;
    check_eq("post_rst_drain", 64'(out_valid), 64'd0);
    check_eq("post_rst_cnt1",  64'(cnt1),      st(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
